scan_display_ctrl: RTL and testbench
====================================

Name: scan_display_ctrl

Overview:
Timing controller for the multiplexed 7-segment display path. It scans N_DIGITS digits from a single system clock using clock-enable ticks, with no derived clocks. It inserts a blanking gap between digits to prevent ghosting, applies per-digit masking and leading-zero suppression, and double-buffers the displayed value so updates take effect only at frame boundaries. Its bcd_out drives the existing BCD-to-7-segment decoder; anode_n drives the digit anodes directly.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8)
DIGIT_CYCLES, 100000, clk cycles per digit slot, blank gap included (1 ms at 100 MHz)
BLANK_CYCLES, 1000, clk cycles at the start of each slot with all anodes off; legal range 1 <= BLANK_CYCLES < DIGIT_CYCLES

Ports:
clk  in  1  system clock, 100 MHz
reset  in  1  asynchronous, active-low reset
value_in  in  4*N_DIGITS  new display value; nibble i is digit i, digit 0 is least significant
load  in  1  request to update the displayed value
load_ack  out  1  one-cycle pulse when a pending value is committed
digit_en_mask  in  N_DIGITS  bit i = 0 forces digit i dark
lz_blank  in  1  enable leading-zero suppression
bcd_out  out  4  nibble for the current digit, to the decoder
digit_sel  out  $clog2(N_DIGITS)  current digit index
anode_n  out  N_DIGITS  active-low anode enables
blank  out  1  1 whenever no anode is driven
frame_start  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (reset = 0, asynchronous):
  - shadow value = 0, pending value = 0, pending flag = 0
  - digit_sel = 0, slot counter = 0, state = BLANK
  - anode_n = all 1, blank = 1, bcd_out = 0, load_ack = 0, frame_start = 0
- All outputs are registered.
- Slot counter counts 0..DIGIT_CYCLES-1 every clk cycle.
- State machine:
  - BLANK: held while counter < BLANK_CYCLES. anode_n = all 1, blank = 1.
  - ON: held while counter >= BLANK_CYCLES. anode_n[digit_sel] = 0 and blank = 0, unless the digit is suppressed. A suppressed digit keeps anode_n all 1 and blank = 1.
- Slot end (counter = DIGIT_CYCLES-1):
  - counter returns to 0, state returns to BLANK
  - digit_sel increments and wraps N_DIGITS-1 -> 0
- bcd_out = shadow nibble[digit_sel]. It updates in the first BLANK cycle of each slot and holds for the whole slot.
  - Nibble values 10..15 pass through unmodified.
- Suppression of digit i = (digit_en_mask[i] == 0) OR (lz_blank AND i != 0 AND shadow nibbles i..N_DIGITS-1 are all zero).
  - Digit 0 is never zero-suppressed, so 0 displays as "0".
  - Suppression is evaluated against the shadow value, so masks and lz_blank are sampled every cycle.
- Load handshake:
  - Any cycle with load = 1 copies value_in into the pending register and sets the pending flag. The latest load wins.
- Frame boundary: the slot-end cycle with digit_sel = N_DIGITS-1. On that edge:
  - If the pending flag is set: shadow <= pending, pending flag cleared, load_ack = 1 for the next cycle.
  - If load = 1 in the boundary cycle itself, that cycle's value_in is committed directly and acked.
  - frame_start = 1 for the first cycle of digit 0's slot.
  - frame_start does not pulse on reset release.
- With no load, shadow never changes.
- The display never shows a mix of old and new nibbles within one frame.
- Reset asserted mid-slot returns to the reset state immediately, with anodes off asynchronously. Pending data is discarded.

Test Plan:
1. Reset values: DIGIT_CYCLES=10, BLANK_CYCLES=2, N_DIGITS=4; hold reset low -> anode_n = 4'b1111, blank = 1, digit_sel = 0, bcd_out = 0. Release -> 2 cycles anode_n = 1111, then 8 cycles anode_n = 1110.
2. Scan order with mask all 1 and lz_blank = 0: anode_n sequence 1110, 1101, 1011, 0111 in ON phases, repeating every 40 cycles. frame_start pulses once per 40 cycles in the first cycle of digit 0.
3. Load mid-frame: load 0x1234 during digit 1. Display stays 0x0000 until the boundary, then load_ack pulses 1 cycle. bcd_out for digits 0..3 = 4, 3, 2, 1 in the next frame. Two loads in one frame (0x1111 then 0x2222) -> only 0x2222 is shown, with one ack.
4. Leading-zero suppression: shadow 0x0042, lz_blank = 1 -> digits 2 and 3 stay dark (anode_n = 1111, blank = 1 in their ON phase); digits 0 and 1 light. Shadow 0x0000 -> only digit 0 lights.
5. Mask: digit_en_mask = 4'b0101 -> only digits 0 and 2 light. Digits 1 and 3 hold blank = 1 for their full slots.
6. Reset mid-operation: assert reset during the ON phase of digit 2 with a load pending -> anode_n = 1111 immediately. After release, shadow = 0 and there is no load_ack.

Source files
------------

// File: rtl/scan_display_ctrl_if.sv
// Bus between the display scan controller and its host/display logic.
interface scan_display_ctrl_if #(
  parameter int N_DIGITS = 4
);
  localparam int DW = $clog2(N_DIGITS);

  logic [4*N_DIGITS-1:0] value_in;
  logic                  load;
  logic                  load_ack;
  logic [N_DIGITS-1:0]   digit_en_mask;
  logic                  lz_blank;
  logic [3:0]            bcd_out;
  logic [DW-1:0]         digit_sel;
  logic [N_DIGITS-1:0]   anode_n;
  logic                  blank;
  logic                  frame_start;

  modport master (
    output value_in, load, digit_en_mask, lz_blank,
    input  load_ack, bcd_out, digit_sel, anode_n, blank, frame_start
  );

  modport slave (
    input  value_in, load, digit_en_mask, lz_blank,
    output load_ack, bcd_out, digit_sel, anode_n, blank, frame_start
  );
endinterface

// File: rtl/scan_display_ctrl.sv
// Multiplexed 7-segment scan timing: blanked digit slots, masking,
// leading-zero suppression and frame-synchronous double buffering.
module scan_display_ctrl #(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  scan_display_ctrl_if.slave bus
);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam int DW = $clog2(N_DIGITS);
  localparam int VW = 4 * N_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] DIG_LAST = DW'(N_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DW-1:0]       digit_q, digit_d;
  logic [VW-1:0]       shadow_q, shadow_d;
  logic [VW-1:0]       pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic                blank_q, blank_d;
  logic                ack_q, ack_d;
  logic                fs_q, fs_d;
  logic [N_DIGITS-1:0] supp;
  logic                hi_zero;
  logic                slot_end;
  logic                frame_end;

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (digit_q == DIG_LAST);

  // Walk from the top digit down so hi_zero means "this nibble and all above are zero".
  always_comb begin
    hi_zero = 1'b1;
    supp    = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      hi_zero = hi_zero && (shadow_q[4*i +: 4] == 4'd0);
      supp[i] = !bus.digit_en_mask[i] || (bus.lz_blank && (i != 0) && hi_zero);
    end
  end

  always_comb begin
    cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
    digit_d    = digit_q;
    state_d    = state_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    shadow_d   = shadow_q;
    ack_d      = 1'b0;
    fs_d       = frame_end;
    bcd_d      = bcd_q;
    anode_d    = '1;

    if (slot_end) begin
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DW'(1);
    end

    case (state_q)
      ST_BLANK: if (cnt_d == CNT_ON) state_d = ST_ON;
      ST_ON:    if (slot_end) state_d = ST_BLANK;
    endcase

    if (bus.load) begin
      pend_d     = bus.value_in;
      pend_vld_d = 1'b1;
    end

    // A load in the boundary cycle itself bypasses the pending register.
    if (frame_end) begin
      if (bus.load) begin
        shadow_d   = bus.value_in;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end else if (pend_vld_q) begin
        shadow_d   = pend_q;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end
    end

    if (slot_end) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (digit_d == DW'(i)) bcd_d = shadow_d[4*i +: 4];
      end
    end

    for (int i = 0; i < N_DIGITS; i++) begin
      if (state_d == ST_ON && digit_d == DW'(i) && !supp[i]) anode_d[i] = 1'b0;
    end
    blank_d = &anode_d;
  end

  // reset is active-low; it drops the anodes without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      digit_q    <= '0;
      shadow_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      bcd_q      <= 4'd0;
      anode_q    <= '1;
      blank_q    <= 1'b1;
      ack_q      <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      digit_q    <= digit_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      bcd_q      <= bcd_d;
      anode_q    <= anode_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      fs_q       <= fs_d;
    end
  end

  assign bus.bcd_out     = bcd_q;
  assign bus.digit_sel   = digit_q;
  assign bus.anode_n     = anode_q;
  assign bus.blank       = blank_q;
  assign bus.load_ack    = ack_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_scan_display_ctrl.sv
// Self-checking bench for scan_display_ctrl against a cycle-position model
// derived from elapsed time since reset release.
module tb_scan_display_ctrl;
  localparam int N  = 4;
  localparam int DC = 10;
  localparam int BC = 2;
  localparam int DW = $clog2(N);
  localparam int VW = 4 * N;
  localparam int OW = N + DW + 7;
  localparam logic [OW-1:0] RESET_VEC = {{N{1'b1}}, 1'b1, 4'h0, {DW{1'b0}}, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset;

  scan_display_ctrl_if #(.N_DIGITS(N)) bus ();

  scan_display_ctrl #(
    .N_DIGITS(N), .DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] obs;
  assign obs = {bus.anode_n, bus.blank, bus.bcd_out, bus.digit_sel, bus.load_ack, bus.frame_start};

  // Model: position is elapsed cycles since reset release; shadow/pending follow the load rules.
  int            m_t;
  logic [VW-1:0] m_shadow;
  logic [VW-1:0] m_pend;
  bit            m_pend_vld;
  bit            m_ack;
  bit            m_fs;
  logic [N-1:0]  m_mask;
  bit            m_lz;

  function automatic int cur_digit();
    return (m_t / DC) % N;
  endfunction

  function automatic int frame();
    return m_t / (DC * N);
  endfunction

  function automatic logic [N-1:0] exp_anode();
    int d = cur_digit();
    if (m_t % DC < BC) return '1;
    if (!m_mask[d]) return '1;
    if (m_lz && d != 0 && (m_shadow >> (4 * d)) == 0) return '1;
    return ~(N'(1) << d);
  endfunction

  function automatic logic [3:0] exp_bcd();
    return 4'(m_shadow >> (4 * cur_digit()));
  endfunction

  function automatic logic [OW-1:0] exp_vec();
    logic [N-1:0] a = exp_anode();
    return {a, &a, exp_bcd(), DW'(cur_digit()), m_ack, m_fs};
  endfunction

  task automatic model_reset();
    m_t        = 0;
    m_shadow   = '0;
    m_pend     = '0;
    m_pend_vld = 0;
    m_ack      = 0;
    m_fs       = 0;
    m_mask     = bus.digit_en_mask;
    m_lz       = bus.lz_blank;
  endtask

  // Advance one clock: update the model with this cycle's inputs, then sample at negedge.
  task automatic tick();
    bit boundary = (m_t % DC == DC - 1) && ((m_t / DC) % N == N - 1);
    if (bus.load) begin
      m_pend     = bus.value_in;
      m_pend_vld = 1;
    end
    m_ack = 0;
    if (boundary && m_pend_vld) begin
      m_shadow   = m_pend;
      m_pend_vld = 0;
      m_ack      = 1;
    end
    m_fs   = boundary;
    m_mask = bus.digit_en_mask;
    m_lz   = bus.lz_blank;
    m_t++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_to(int digit, int phase);
    for (int k = 0; k < 2 * DC * N; k++) begin
      if (cur_digit() == digit && m_t % DC == phase) break;
      tick();
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++;
      $display("[TB] FAIL reset_hold: got %h expected %h", obs, RESET_VEC);
    end
    model_reset();
    reset = 1'b1;
    for (int k = 0; k < DC; k++) begin
      n_checks++;
      if (bus.anode_n !== ((k < BC) ? {N{1'b1}} : ~N'(1))) begin
        n_fail++;
        $display("[TB] FAIL reset_release_anode: k=%0d got %b", k, bus.anode_n);
      end
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL reset_release: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_scan();
    int fs_count = 0;
    for (int k = 0; k < 2 * DC * N; k++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL scan: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
      if (m_t % DC >= BC) begin
        n_checks++;
        if (bus.anode_n !== ~(N'(1) << cur_digit())) begin
          n_fail++;
          $display("[TB] FAIL scan_anode: t=%0d got %b", m_t, bus.anode_n);
        end
      end
      if (bus.frame_start === 1'b1) fs_count++;
      tick();
    end
    n_checks++;
    if (fs_count != 2) begin
      n_fail++;
      $display("[TB] FAIL scan_frame_start_count: got %0d expected 2", fs_count);
    end
  endtask

  task automatic test_load();
    int acks;
    int f0;
    logic [3:0] want [N] = '{4'd4, 4'd3, 4'd2, 4'd1};

    run_to(1, 4);
    bus.value_in = VW'(16'h1234);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    f0 = frame();
    acks = 0;
    for (int k = 0; k < 3 * DC * N && frame() <= f0 + 1; k++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL load_single: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
      if (frame() == f0 + 1 && m_t % DC == 5) begin
        n_checks++;
        if (bus.bcd_out !== want[cur_digit()]) begin
          n_fail++;
          $display("[TB] FAIL load_bcd: digit %0d got %h expected %h", cur_digit(), bus.bcd_out, want[cur_digit()]);
        end
      end
      if (bus.load_ack === 1'b1) acks++;
      tick();
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("[TB] FAIL load_single_acks: got %0d expected 1", acks);
    end

    run_to(0, 0);
    bus.value_in = VW'(16'h1111);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    run_to(2, 3);
    bus.value_in = VW'(16'h2222);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    f0 = frame();
    acks = 0;
    for (int k = 0; k < 3 * DC * N && frame() <= f0 + 1; k++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL load_double: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
      if (frame() == f0 + 1 && m_t % DC == 5) begin
        n_checks++;
        if (bus.bcd_out !== 4'd2) begin
          n_fail++;
          $display("[TB] FAIL load_double_bcd: digit %0d got %h expected 2", cur_digit(), bus.bcd_out);
        end
      end
      if (bus.load_ack === 1'b1) acks++;
      tick();
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++;
      $display("[TB] FAIL load_double_acks: got %0d expected 1", acks);
    end
  endtask

  task automatic test_lz();
    logic [VW-1:0] vals [2] = '{VW'(16'h0042), VW'(16'h0000)};
    int nlit [2] = '{2, 1};
    for (int c = 0; c < 2; c++) begin
      run_to(0, 0);
      bus.value_in = vals[c];
      bus.load = 1'b1;
      tick();
      bus.load = 1'b0;
      run_to(0, 0);
      bus.lz_blank = 1'b1;
      for (int k = 0; k < DC * N; k++) begin
        n_checks++;
        if (obs !== exp_vec()) begin
          n_fail++;
          $display("[TB] FAIL lz: t=%0d got %h expected %h", m_t, obs, exp_vec());
        end
        if (m_t % DC == BC + 1) begin
          n_checks++;
          if (bus.blank !== (cur_digit() >= nlit[c])) begin
            n_fail++;
            $display("[TB] FAIL lz_blank: value %h digit %0d got blank=%b", vals[c], cur_digit(), bus.blank);
          end
        end
        tick();
      end
    end
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_mask();
    int dark = 0;
    int lit  = 0;
    run_to(0, 0);
    bus.digit_en_mask = 4'b0101;
    bus.lz_blank = 1'b0;
    for (int k = 0; k < DC * N; k++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL mask: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
      if (cur_digit() % 2 == 1 && bus.blank === 1'b1) dark++;
      if (cur_digit() % 2 == 0 && bus.blank === 1'b0) lit++;
      tick();
    end
    n_checks++;
    if (dark != 2 * DC || lit != 2 * (DC - BC)) begin
      n_fail++;
      $display("[TB] FAIL mask_counts: dark=%0d lit=%0d expected %0d/%0d", dark, lit, 2 * DC, 2 * (DC - BC));
    end
    bus.digit_en_mask = '1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      bus.load = ($urandom_range(0, 7) == 0);
      bus.value_in = VW'($urandom) >> (4 * $urandom_range(0, N));
      if ($urandom_range(0, 29) == 0) bus.digit_en_mask = N'($urandom);
      if ($urandom_range(0, 29) == 0) bus.lz_blank = 1'($urandom);
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
    end
    bus.load = 1'b0;
    bus.digit_en_mask = '1;
    bus.lz_blank = 1'b0;
  endtask

  task automatic test_mid_reset();
    int acks = 0;
    run_to(0, 3);
    bus.value_in = VW'(16'hABCD);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    run_to(2, 5);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (obs !== RESET_VEC) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_async: got %h expected %h", obs, RESET_VEC);
    end
    @(negedge clk);
    reset_dut();
    for (int k = 0; k < 2 * DC * N; k++) begin
      n_checks++;
      if (obs !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_after: t=%0d got %h expected %h", m_t, obs, exp_vec());
      end
      n_checks++;
      if (bus.bcd_out !== 4'd0) begin
        n_fail++;
        $display("[TB] FAIL mid_reset_bcd: t=%0d got %h expected 0", m_t, bus.bcd_out);
      end
      if (bus.load_ack === 1'b1) acks++;
      tick();
    end
    n_checks++;
    if (acks != 0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_acks: got %0d expected 0", acks);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.load = 1'b0;
    bus.value_in = '0;
    bus.digit_en_mask = '1;
    bus.lz_blank = 1'b0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_load();
    test_lz();
    test_mask();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
